simple_alu_axil_slave: RTL and testbench
========================================

# simple_alu_axil_slave

AXI4-Lite slave register front-end and execution stage of the simple_alu IP; it sits directly downstream of the AXI master on the S00_AXI port. It exposes four 32-bit registers: operand A, operand B, control/opcode and a read-only result. A control write launches a one-cycle ALU operation, and the result is committed before the write response is returned, so any read issued after BRESP observes the new result.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; four word registers.
- s00_axi_aclk  in  1  single clock; all logic on the rising edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel; ARPROT is ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.

## Operation
- Register map, decoded on addr[3:2] (addr[1:0] ignored):
  - 0x0 OPA: RW.
  - 0x4 OPB: RW.
  - 0x8 CTRL: RW; bits [2:0] are the opcode; bits [31:3] read as 0.
  - 0xC RESULT: RO.
- WSTRB byte enables apply to OPA, OPB and CTRL. A CTRL write with WSTRB[0]=0 leaves the opcode unchanged but still triggers execution.
- Opcodes (32-bit wrap arithmetic):
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A<<B[4:0].
  - 6 SRL: A>>B[4:0], logical.
  - 7 SLT: signed compare, 1 if A<B, else 0.
- Execution is triggered by any write to 0x8. RESULT is computed from the post-write OPA, OPB and opcode. Writes to OPA or OPB do not recompute RESULT.
- A write to 0xC is a no-op on all registers and returns BRESP=SLVERR (2'b10). All other writes return OKAY. All reads return RRESP=OKAY.
- Write FSM states: W_IDLE, W_ADDR (AW captured, waiting for W), W_DATA (W captured, waiting for AW), W_COMMIT, W_EXEC, W_RESP.
  - W_IDLE → W_COMMIT when both handshakes complete in the same cycle; otherwise → W_ADDR or W_DATA.
  - W_ADDR / W_DATA → W_COMMIT when the missing handshake completes.
  - W_COMMIT → W_EXEC if the target is CTRL; otherwise → W_RESP.
  - W_EXEC → W_RESP.
  - W_RESP → W_IDLE on BREADY.
- Read FSM states: R_IDLE, R_RESP. AR is accepted in R_IDLE; RDATA is captured from the register contents at the accepting edge; R_RESP → R_IDLE on RREADY.
- Read and write paths are independent and may overlap. A read accepted on the same edge as a register update returns the pre-update value.

## Timing
- Reset values: all registers, BVALID, RVALID, BRESP, RRESP and RDATA = 0; FSMs in W_IDLE and R_IDLE.
- AWREADY is high only in W_IDLE or W_DATA. WREADY is high only in W_IDLE or W_ADDR. ARREADY is high only in R_IDLE. None of these may depend combinationally on the corresponding VALID.
- Write latency, with both handshakes at edge N:
  - Register updated at N+1.
  - For a CTRL write, RESULT updated and BVALID rising at N+2.
  - For other addresses, BVALID rises at N+1 together with the update.
- Read latency: AR handshake at edge N; RVALID and RDATA valid after N; RDATA held stable until the RREADY handshake.
- BVALID and RVALID stay high until their handshake. There is at most one outstanding write and one outstanding read.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronously); in-flight transactions are dropped and no response is issued.

## Structure
- Package simple_alu_pkg holds:
  - the alu_op_e enum (the eight opcodes);
  - register offset localparams (OPA 0, OPB 1, CTRL 2, RESULT 3);
  - RESP_OKAY and RESP_SLVERR;
  - the write and read FSM state enums.
- Sub-module simple_alu_core: purely combinational (op, a, b) → y. It is instantiated once; its output is registered into RESULT in W_EXEC.

## Test plan
- Reset, then read 0x0, 0x4, 0x8, 0xC → all 0x00000000 with OKAY.
- Write OPA=0x00000005, OPB=0x00000003, CTRL=1 → read 0xC = 0x00000002. Then CTRL=7 → 0xC = 0x00000000. Then OPA=0xFFFFFFFF with CTRL=7 → 0xC = 0x00000001.
- Write W one cycle before AW, then AW before W, with BREADY held low for 5 cycles → BVALID stays high for all 5 cycles, no second AW is accepted meanwhile, and data is written correctly.
- Write OPA=0x12345678 with WSTRB=4'b0101 over a prior value of 0xFFFFFFFF → read returns 0xFF34FF78.
- Write 0xDEADBEEF to 0xC → BRESP=SLVERR and RESULT unchanged. Write CTRL=0xFFFFFFFF → read 0x8 = 0x00000007.
- Deassert aresetn while RVALID is pending and while in W_ADDR → outputs clear immediately, the next transaction completes normally, and all registers read as 0.

Source files
------------

// File: rtl/simple_alu_pkg.sv
// -----------------------------------------------------------------------------
// simple_alu_pkg
// Shared definitions for the simple_alu AXI4-Lite slave:
//   - alu_op_e      : the eight ALU opcodes held in CTRL[2:0]
//   - REG_*         : word offsets of the four registers (addr[3:2])
//   - RESP_*        : AXI response codes used by the slave
//   - wr_state_e    : write-channel FSM states
//   - rd_state_e    : read-channel FSM states
//   - apply_wstrb() : byte-enable merge of new write data over a register
// -----------------------------------------------------------------------------
package simple_alu_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    localparam logic [1:0] REG_OPA    = 2'd0;
    localparam logic [1:0] REG_OPB    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_ADDR   = 3'd1,
        W_DATA   = 3'd2,
        W_COMMIT = 3'd3,
        W_EXEC   = 3'd4,
        W_RESP   = 3'd5
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Replace only the bytes whose strobe is set; the rest keep their old value.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/simple_alu_core.sv
// -----------------------------------------------------------------------------
// simple_alu_core
// Purely combinational ALU: y = f(op, a, b) with 32-bit wrap-around arithmetic.
// Ports:
//   op [2:0]  in   opcode (see alu_op_e)
//   a  [31:0] in   operand A
//   b  [31:0] in   operand B (only b[4:0] is used as the shift amount)
//   y  [31:0] out  result
// -----------------------------------------------------------------------------
import simple_alu_pkg::*;

module simple_alu_core (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            // Signed comparison; the result is a single 0/1 flag.
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/simple_alu_axil_slave.sv
// -----------------------------------------------------------------------------
// simple_alu_axil_slave
// AXI4-Lite register front-end and execution stage of the simple_alu IP.
// Registers (decoded on addr[3:2]):
//   0x0 OPA (RW), 0x4 OPB (RW), 0x8 CTRL (RW, opcode in [2:0]), 0xC RESULT (RO)
// Any write to CTRL runs one ALU operation on the post-write operands; RESULT
// is committed before BVALID rises, so a read after BRESP sees the new value.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn      clock, asynchronous active-low reset
//   s00_axi_aw*  write address channel  (AWPROT ignored)
//   s00_axi_w*   write data channel
//   s00_axi_b*   write response channel (SLVERR for writes to RESULT)
//   s00_axi_ar*  read address channel   (ARPROT ignored)
//   s00_axi_r*   read data channel      (always OKAY)
// -----------------------------------------------------------------------------
import simple_alu_pkg::*;

module simple_alu_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
);

    wr_state_e         w_state;
    rd_state_e         r_state;

    logic [1:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    alu_op_e           opcode;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu_y;

    logic [1:0]        bresp;
    logic              bvalid;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused;
    assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    simple_alu_core u_core (
        .op (opcode),
        .a  (opa),
        .b  (opb),
        .y  (alu_y)
    );

    // Ready signals come from state alone, never from the matching VALID.
    assign s00_axi_awready = (w_state == W_IDLE) || (w_state == W_DATA);
    assign s00_axi_wready  = (w_state == W_IDLE) || (w_state == W_ADDR);
    assign s00_axi_arready = (r_state == R_IDLE);

    assign s00_axi_bresp   = bresp;
    assign s00_axi_bvalid  = bvalid;
    assign s00_axi_rdata   = rdata;
    assign s00_axi_rresp   = RESP_OKAY;
    assign s00_axi_rvalid  = rvalid;

    // Write path: collect AW and W in either order, commit the register write,
    // optionally run the ALU, then hold the response until BREADY.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            opa     <= '0;
            opb     <= '0;
            opcode  <= ALU_ADD;
            result  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s00_axi_awvalid) begin
                        wr_addr <= s00_axi_awaddr[3:2];
                    end
                    if (s00_axi_wvalid) begin
                        wr_data <= s00_axi_wdata;
                        wr_strb <= s00_axi_wstrb;
                    end
                    if (s00_axi_awvalid && s00_axi_wvalid) begin
                        w_state <= W_COMMIT;
                    end else if (s00_axi_awvalid) begin
                        w_state <= W_ADDR;
                    end else if (s00_axi_wvalid) begin
                        w_state <= W_DATA;
                    end
                end
                W_ADDR: begin
                    if (s00_axi_wvalid) begin
                        wr_data <= s00_axi_wdata;
                        wr_strb <= s00_axi_wstrb;
                        w_state <= W_COMMIT;
                    end
                end
                W_DATA: begin
                    if (s00_axi_awvalid) begin
                        wr_addr <= s00_axi_awaddr[3:2];
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    case (wr_addr)
                        REG_OPA:  opa <= apply_wstrb(opa, wr_data, wr_strb);
                        REG_OPB:  opb <= apply_wstrb(opb, wr_data, wr_strb);
                        REG_CTRL: begin
                            // Opcode lives in byte 0; without that strobe the
                            // previous opcode is re-executed.
                            if (wr_strb[0]) begin
                                opcode <= alu_op_e'(wr_data[2:0]);
                            end
                        end
                        default: ;
                    endcase
                    if (wr_addr == REG_CTRL) begin
                        w_state <= W_EXEC;
                    end else begin
                        bvalid  <= 1'b1;
                        bresp   <= (wr_addr == REG_RESULT) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_EXEC: begin
                    // Operands and opcode already hold their post-write values.
                    result  <= alu_y;
                    bvalid  <= 1'b1;
                    bresp   <= RESP_OKAY;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        bvalid  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: snapshot the addressed register on the AR handshake edge and
    // hold it until RREADY.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= R_IDLE;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s00_axi_arvalid) begin
                        case (s00_axi_araddr[3:2])
                            REG_OPA:  rdata <= opa;
                            REG_OPB:  rdata <= opb;
                            REG_CTRL: rdata <= {{(DATA_W-3){1'b0}}, opcode};
                            default:  rdata <= result;
                        endcase
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s00_axi_rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_alu_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_simple_alu_axil_slave
// Directed, table-driven bench for simple_alu_axil_slave: an ALU vector table
// plus hand-written sequences for latency, channel ordering, back-pressure,
// byte strobes, SLVERR and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_simple_alu_axil_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks;
    int failures;

    simple_alu_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        resp = 2'b11;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
            @(negedge clk);
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout_fail("write_addr_data");
        end else begin
            bready = 1'b1;
            n = 0;
            while (!bvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bvalid) begin
                timeout_fail("write_resp");
            end else begin
                resp = bresp;
                @(posedge clk); #1;
            end
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_hs;
        int n;
        data = 32'hxxxx_xxxx;
        resp = 2'b11;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        ar_hs = 0; n = 0;
        while (!ar_hs && n < 20) begin
            ar_hs = arready;
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        if (!ar_hs) begin
            timeout_fail("read_addr");
        end else begin
            n = 0;
            while (!rvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!rvalid) begin
                timeout_fail("read_data");
            end else begin
                data = rdata;
                resp = rresp;
                rready = 1'b1;
                @(posedge clk); #1;
                rready = 1'b0;
            end
        end
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;

    initial begin
        checks = 0;
        failures = 0;
        // op, A, B, expected RESULT
        vecs[0]  = '{3'd1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002};
        vecs[1]  = '{3'd7, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};
        vecs[2]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0001};
        vecs[3]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[4]  = '{3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[6]  = '{3'd3, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
        vecs[7]  = '{3'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA};
        vecs[8]  = '{3'd5, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        vecs[10] = '{3'd7, 32'h0000_0003, 32'h8000_0000, 32'h0000_0000};
        vecs[11] = '{3'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        vecs[12] = '{3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        rst_n = 1'b1;

        // Reset contents of every register
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr);
            chk($sformatf("rst_reg%0d", i), rd, 32'd0);
            chk($sformatf("rst_rresp%0d", i), {30'd0, rr}, 32'd0);
        end

        // ALU vector table
        for (int i = 0; i < NV; i++) begin
            axi_write(4'h0, vecs[i].a, 4'hF, resp);
            axi_write(4'h4, vecs[i].b, 4'hF, resp);
            axi_write(4'h8, {29'd0, vecs[i].op}, 4'hF, resp);
            chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, 32'd0);
            axi_read(4'hC, rd, rr);
            chk($sformatf("vec%0d_result", i), rd, vecs[i].exp);
        end

        // Latency: non-CTRL write responds one edge after the handshake
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("lat_opa_n0_bvalid", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        chk("lat_opa_n1_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("lat_opa_bvalid_drop", {31'd0, bvalid}, 32'd0);

        // Latency: CTRL write responds two edges after the handshake
        awaddr = 4'h8; wdata = 32'h0000_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("lat_ctrl_n0_bvalid", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        chk("lat_ctrl_n1_bvalid", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        chk("lat_ctrl_n2_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(4'hC, rd, rr);
        chk("lat_ctrl_result", rd, 32'hA5A5_0001 + 32'h7FFF_FFFF);

        // Byte strobes
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, resp);
        axi_write(4'h0, 32'h1234_5678, 4'b0101, resp);
        axi_read(4'h0, rd, rr);
        chk("wstrb_opa", rd, 32'hFF34_FF78);

        // Operand writes do not recompute; CTRL with strobe 0 re-executes old op
        axi_write(4'h0, 32'd5, 4'hF, resp);
        axi_write(4'h4, 32'd3, 4'hF, resp);
        axi_write(4'h8, 32'd0, 4'hF, resp);
        axi_read(4'hC, rd, rr);
        chk("add_5_3", rd, 32'd8);
        axi_write(4'h0, 32'd10, 4'hF, resp);
        axi_read(4'hC, rd, rr);
        chk("no_recompute_on_opa", rd, 32'd8);
        axi_write(4'h8, 32'd1, 4'b1110, resp);
        axi_read(4'h8, rd, rr);
        chk("ctrl_strb0_opcode", rd, 32'd0);
        axi_read(4'hC, rd, rr);
        chk("ctrl_strb0_exec", rd, 32'd13);

        // RESULT is read-only; CTRL upper bits read back as zero
        axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, resp);
        chk("result_write_slverr", {30'd0, resp}, 32'd2);
        axi_read(4'hC, rd, rr);
        chk("result_unchanged", rd, 32'd13);
        axi_read(4'h0, rd, rr);
        chk("opa_unchanged", rd, 32'd10);
        axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, resp);
        axi_read(4'h8, rd, rr);
        chk("ctrl_upper_zero", rd, 32'd7);
        axi_read(4'hC, rd, rr);
        chk("slt_10_3", rd, 32'd0);

        // W before AW, then BREADY held low for 5 cycles with a competing AW
        @(negedge clk);
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        chk("wfirst_awready", {31'd0, awready}, 32'd1);
        chk("wfirst_wready", {31'd0, wready}, 32'd0);
        awaddr = 4'h4; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bvalid) timeout_fail("wfirst_bvalid");
        end
        awaddr = 4'h0; wdata = 32'h0BAD_0BAD; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_bvalid", i), {31'd0, bvalid}, 32'd1);
            chk($sformatf("hold%0d_awready", i), {31'd0, awready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(4'h4, rd, rr);
        chk("wfirst_opb", rd, 32'hCAFE_F00D);
        axi_read(4'h0, rd, rr);
        chk("hold_no_extra_aw", rd, 32'd10);

        // AW before W
        @(negedge clk);
        awaddr = 4'h0; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("awfirst_wready", {31'd0, wready}, 32'd1);
        chk("awfirst_awready", {31'd0, awready}, 32'd0);
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        bready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bvalid) timeout_fail("awfirst_bvalid");
            else chk("awfirst_bresp", {30'd0, bresp}, 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(4'h0, rd, rr);
        chk("awfirst_opa", rd, 32'h0BAD_F00D);

        // Asynchronous reset with a read pending and the write FSM in W_ADDR
        @(negedge clk);
        araddr = 4'h0; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        awaddr = 4'h4; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        chk("pre_rst_rdata", rdata, 32'h0BAD_F00D);
        chk("pre_rst_awready", {31'd0, awready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        chk("async_rst_awready", {31'd0, awready}, 32'd1);
        chk("async_rst_bvalid", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr);
            chk($sformatf("post_rst_reg%0d", i), rd, 32'd0);
        end
        axi_write(4'h4, 32'h0000_0011, 4'hF, resp);
        chk("post_rst_bresp", {30'd0, resp}, 32'd0);
        axi_read(4'h4, rd, rr);
        chk("post_rst_opb", rd, 32'h0000_0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
